// File: rtl/vic_pkg.sv
// Shared types, the fixed C64 colour palette and the PAL/NTSC geometry defaults
// for the VIC raster core.
package vic_pkg;

  typedef logic [3:0] col_idx_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // C64 colours reduced to 4 bits per channel, indexed by the VIC colour number.
  localparam rgb12_t C64_PALETTE [16] = '{
    12'h000, 12'hFFF, 12'h632, 12'h7AB,
    12'h638, 12'h584, 12'h327, 12'hBC6,
    12'h642, 12'h430, 12'h965, 12'h444,
    12'h666, 12'h9D8, 12'h65B, 12'h999
  };

  localparam int DEF_DOTS_PER_CYCLE = 8;
  localparam int DEF_PAL_CYCLES     = 63;
  localparam int DEF_PAL_LINES      = 312;
  localparam int DEF_NTSC_CYCLES    = 65;
  localparam int DEF_NTSC_LINES     = 263;

endpackage

// File: rtl/vic_palette.sv
// Registered colour-index to 12-bit RGB lookup; blanks to black outside the
// visible region.
module vic_palette
  import vic_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  col_idx_t i_idx,
  input  logic     i_vis,
  output rgb12_t   o_rgb
);

  rgb12_t r_rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= i_vis ? C64_PALETTE[i_idx] : '0;
    end
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/vic_raster_timing.sv
// Raster/clock core: dot/cycle/line counters, phi0 generation, syncs, raster
// interrupt and border/background colour output with runtime PAL/NTSC geometry.
module vic_raster_timing
  import vic_pkg::*;
#(
  parameter int DOTS_PER_CYCLE = DEF_DOTS_PER_CYCLE,
  parameter int PAL_CYCLES     = DEF_PAL_CYCLES,
  parameter int PAL_LINES      = DEF_PAL_LINES,
  parameter int NTSC_CYCLES    = DEF_NTSC_CYCLES,
  parameter int NTSC_LINES     = DEF_NTSC_LINES,
  parameter int HS_START       = 58,
  parameter int HS_LEN         = 4,
  parameter int VS_START       = 300,
  parameter int VS_LEN         = 3,
  parameter int WIN_C0         = 16,
  parameter int WIN_C1         = 56,
  parameter int WIN_L0         = 51,
  parameter int WIN_L1         = 251,
  parameter int VIS_L0         = 16,
  parameter int VIS_L1         = 288,
  parameter int VIS_C0         = 12,
  parameter int VIS_C1         = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ntsc,
  input  logic [8:0] i_irq_line,
  input  logic       i_irq_en,
  input  logic       i_irq_ack,
  input  logic [3:0] i_border_col,
  input  logic [3:0] i_bg_col,
  output logic       o_phi0,
  output logic       o_phi0_rise,
  output logic       o_phi0_fall,
  output logic [2:0] o_dot,
  output logic [6:0] o_cycle,
  output logic [8:0] o_line,
  output logic       o_ntsc_active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_display_on,
  output logic       o_irq_pending,
  output logic       o_irq,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue
);

  localparam logic [2:0] DOT_LAST  = 3'(DOTS_PER_CYCLE - 1);
  localparam logic [2:0] DOT_HALF  = 3'(DOTS_PER_CYCLE / 2);
  localparam logic [2:0] DOT_RISE  = 3'(DOTS_PER_CYCLE / 2 - 1);
  localparam logic [6:0] PAL_CLAST = 7'(PAL_CYCLES - 1);
  localparam logic [6:0] NTS_CLAST = 7'(NTSC_CYCLES - 1);
  localparam logic [8:0] PAL_LLAST = 9'(PAL_LINES - 1);
  localparam logic [8:0] NTS_LLAST = 9'(NTSC_LINES - 1);

  // Sync and window bounds kept 32 bits wide so a start beyond the frame
  // simply never matches instead of wrapping.
  localparam logic [31:0] HS_LO   = 32'(HS_START);
  localparam logic [31:0] HS_HI   = 32'(HS_START + HS_LEN);
  localparam logic [31:0] VSP_LO  = 32'(VS_START);
  localparam logic [31:0] VSP_HI  = 32'(VS_START + VS_LEN);
  localparam logic [31:0] VSN_LO  = 32'(VS_START % NTSC_LINES);
  localparam logic [31:0] VSN_HI  = 32'((VS_START % NTSC_LINES) + VS_LEN);
  localparam logic [31:0] WC0     = 32'(WIN_C0);
  localparam logic [31:0] WC1     = 32'(WIN_C1);
  localparam logic [31:0] WL0     = 32'(WIN_L0);
  localparam logic [31:0] WL1     = 32'(WIN_L1);
  localparam logic [31:0] VC0     = 32'(VIS_C0);
  localparam logic [31:0] VC1     = 32'(VIS_C1);
  localparam logic [31:0] VL0     = 32'(VIS_L0);
  localparam logic [31:0] VL1     = 32'(VIS_L1);

  logic [2:0]  r_dot;
  logic [6:0]  r_cycle;
  logic [8:0]  r_line;
  logic        r_ntsc_active;
  logic        r_phi0;
  logic        r_phi0_rise;
  logic        r_phi0_fall;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_display_on;
  logic        r_irq_pending;

  logic [6:0]  w_cyc_last;
  logic [8:0]  w_line_last;
  logic        w_dot_wrap;
  logic        w_cyc_wrap;
  logic        w_frame_wrap;
  logic [2:0]  w_dot_nxt;
  logic [31:0] w_cyc32;
  logic [31:0] w_line32;
  logic [31:0] w_vs_lo;
  logic [31:0] w_vs_hi;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_visible;
  logic        w_inwin;
  logic        w_irq_hit;
  col_idx_t    w_idx;
  rgb12_t      w_rgb;

  assign w_cyc_last   = r_ntsc_active ? NTS_CLAST : PAL_CLAST;
  assign w_line_last  = r_ntsc_active ? NTS_LLAST : PAL_LLAST;
  assign w_dot_wrap   = (r_dot == DOT_LAST);
  assign w_cyc_wrap   = w_dot_wrap && (r_cycle == w_cyc_last);
  assign w_frame_wrap = w_cyc_wrap && (r_line == w_line_last);
  assign w_dot_nxt    = w_dot_wrap ? 3'd0 : r_dot + 3'd1;

  assign w_cyc32   = {25'd0, r_cycle};
  assign w_line32  = {23'd0, r_line};
  assign w_vs_lo   = r_ntsc_active ? VSN_LO : VSP_LO;
  assign w_vs_hi   = r_ntsc_active ? VSN_HI : VSP_HI;
  assign w_hsync   = (w_cyc32 >= HS_LO) && (w_cyc32 < HS_HI);
  assign w_vsync   = (w_line32 >= w_vs_lo) && (w_line32 < w_vs_hi);
  assign w_visible = (w_cyc32 >= VC0) && (w_cyc32 < VC1) &&
                     (w_line32 >= VL0) && (w_line32 < VL1);
  assign w_inwin   = (w_cyc32 >= WC0) && (w_cyc32 < WC1) &&
                     (w_line32 >= WL0) && (w_line32 < WL1);
  assign w_idx     = w_inwin ? i_bg_col : i_border_col;
  // Lines at or beyond the frame length never occur, so such compares never hit.
  assign w_irq_hit = (r_dot == 3'd0) && (r_cycle == 7'd0) && (r_line == i_irq_line);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dot         <= '0;
      r_cycle       <= '0;
      r_line        <= '0;
      r_ntsc_active <= 1'b0;
      r_phi0        <= 1'b0;
      r_phi0_rise   <= 1'b0;
      r_phi0_fall   <= 1'b0;
    end else begin
      r_dot <= w_dot_nxt;
      if (w_dot_wrap) begin
        r_cycle <= (r_cycle == w_cyc_last) ? 7'd0 : r_cycle + 7'd1;
      end
      if (w_cyc_wrap) begin
        r_line <= (r_line == w_line_last) ? 9'd0 : r_line + 9'd1;
      end
      if (w_frame_wrap) begin
        r_ntsc_active <= i_ntsc;
      end
      // phi0 and strobes are registered from the next dot so they line up with o_dot.
      r_phi0      <= (w_dot_nxt >= DOT_HALF);
      r_phi0_rise <= (w_dot_nxt == DOT_RISE);
      r_phi0_fall <= (w_dot_nxt == DOT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_display_on  <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_hsync      <= w_hsync;
      r_vsync      <= w_vsync;
      r_display_on <= w_visible;
      if (w_irq_hit) begin
        r_irq_pending <= 1'b1;
      end else if (i_irq_ack) begin
        r_irq_pending <= 1'b0;
      end
    end
  end

  vic_palette u_palette (
    .clk   (clk),
    .reset (reset),
    .i_idx (w_idx),
    .i_vis (w_visible),
    .o_rgb (w_rgb)
  );

  assign o_phi0        = r_phi0;
  assign o_phi0_rise   = r_phi0_rise;
  assign o_phi0_fall   = r_phi0_fall;
  assign o_dot         = r_dot;
  assign o_cycle       = r_cycle;
  assign o_line        = r_line;
  assign o_ntsc_active = r_ntsc_active;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_display_on  = r_display_on;
  assign o_irq_pending = r_irq_pending;
  assign o_irq         = r_irq_pending & i_irq_en;
  assign o_red         = w_rgb.r;
  assign o_green       = w_rgb.g;
  assign o_blue        = w_rgb.b;

endmodule

// File: tb/tb_vic_raster_timing.sv
// Randomized bench for vic_raster_timing on a shrunken geometry; expected values
// come from an elapsed-time model of the raster rules.
module tb_vic_raster_timing;

  localparam int D   = 8;
  localparam int PC  = 12;
  localparam int PL  = 20;
  localparam int NC  = 14;
  localparam int NL  = 17;
  localparam int HSS = 9;
  localparam int HSL = 2;
  localparam int VSS = 18;
  localparam int VSL = 3;
  localparam int WC0 = 4;
  localparam int WC1 = 9;
  localparam int WL0 = 5;
  localparam int WL1 = 14;
  localparam int VL0 = 2;
  localparam int VL1 = 18;
  localparam int VC0 = 2;
  localparam int VC1 = 11;

  localparam logic [11:0] PALT [16] = '{
    12'h000, 12'hFFF, 12'h632, 12'h7AB,
    12'h638, 12'h584, 12'h327, 12'hBC6,
    12'h642, 12'h430, 12'h965, 12'h444,
    12'h666, 12'h9D8, 12'h65B, 12'h999
  };

  logic       clk;
  logic       reset;
  logic       i_ntsc;
  logic [8:0] i_irq_line;
  logic       i_irq_en;
  logic       i_irq_ack;
  logic [3:0] i_border_col;
  logic [3:0] i_bg_col;
  logic       o_phi0, o_phi0_rise, o_phi0_fall;
  logic [2:0] o_dot;
  logic [6:0] o_cycle;
  logic [8:0] o_line;
  logic       o_ntsc_active, o_hsync, o_vsync, o_display_on;
  logic       o_irq_pending, o_irq;
  logic [3:0] o_red, o_green, o_blue;

  vic_raster_timing #(
    .DOTS_PER_CYCLE(D), .PAL_CYCLES(PC), .PAL_LINES(PL),
    .NTSC_CYCLES(NC), .NTSC_LINES(NL),
    .HS_START(HSS), .HS_LEN(HSL), .VS_START(VSS), .VS_LEN(VSL),
    .WIN_C0(WC0), .WIN_C1(WC1), .WIN_L0(WL0), .WIN_L1(WL1),
    .VIS_L0(VL0), .VIS_L1(VL1), .VIS_C0(VC0), .VIS_C1(VC1)
  ) dut (
    .clk(clk), .reset(reset), .i_ntsc(i_ntsc), .i_irq_line(i_irq_line),
    .i_irq_en(i_irq_en), .i_irq_ack(i_irq_ack),
    .i_border_col(i_border_col), .i_bg_col(i_bg_col),
    .o_phi0(o_phi0), .o_phi0_rise(o_phi0_rise), .o_phi0_fall(o_phi0_fall),
    .o_dot(o_dot), .o_cycle(o_cycle), .o_line(o_line),
    .o_ntsc_active(o_ntsc_active), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_display_on(o_display_on), .o_irq_pending(o_irq_pending), .o_irq(o_irq),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: clocks elapsed since the current frame began, plus the mode in force.
  int e, m, pend, x_hs, x_vs, x_de, x_rgb;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cpl(input int mode);
    return mode != 0 ? NC : PC;
  endfunction

  function automatic int lpf(input int mode);
    return mode != 0 ? NL : PL;
  endfunction

  task model_reset();
    e = 0; m = 0; pend = 0; x_hs = 0; x_vs = 0; x_de = 0; x_rgb = 0;
  endtask

  task model_edge();
    int cp, d, c, l, vs0, vis, win;
    cp  = cpl(m);
    d   = e % D;
    c   = (e / D) % cp;
    l   = e / (D * cp);
    vs0 = (m != 0) ? (VSS % NL) : VSS;
    vis = (c >= VC0 && c < VC1 && l >= VL0 && l < VL1) ? 1 : 0;
    win = (c >= WC0 && c < WC1 && l >= WL0 && l < WL1) ? 1 : 0;
    x_hs  = (c >= HSS && c < HSS + HSL) ? 1 : 0;
    x_vs  = (l >= vs0 && l < vs0 + VSL) ? 1 : 0;
    x_de  = vis;
    x_rgb = (vis != 0) ? int'(PALT[(win != 0) ? i_bg_col : i_border_col]) : 0;
    if (d == 0 && c == 0 && l == int'(i_irq_line)) pend = 1;
    else if (i_irq_ack) pend = 0;
    if (e == D * cp * lpf(m) - 1) begin
      e = 0;
      m = int'(i_ntsc);
    end else begin
      e++;
    end
  endtask

  task check_all();
    int cp, d, c, l;
    cp = cpl(m);
    d  = e % D;
    c  = (e / D) % cp;
    l  = e / (D * cp);
    chk("dot",         int'(o_dot),         d);
    chk("cycle",       int'(o_cycle),       c);
    chk("line",        int'(o_line),        l);
    chk("phi0",        int'(o_phi0),        (d >= D / 2) ? 1 : 0);
    chk("phi0_rise",   int'(o_phi0_rise),   (d == D / 2 - 1) ? 1 : 0);
    chk("phi0_fall",   int'(o_phi0_fall),   (d == D - 1) ? 1 : 0);
    chk("ntsc_active", int'(o_ntsc_active), m);
    chk("hsync",       int'(o_hsync),       x_hs);
    chk("vsync",       int'(o_vsync),       x_vs);
    chk("display_on",  int'(o_display_on),  x_de);
    chk("irq_pending", int'(o_irq_pending), pend);
    chk("irq",         int'(o_irq),         pend & int'(i_irq_en));
    chk("rgb",         int'({o_red, o_green, o_blue}), x_rgb);
  endtask

  initial begin
    reset = 1'b1; i_ntsc = 1'b0; i_irq_line = 9'd5; i_irq_en = 1'b0;
    i_irq_ack = 1'b0; i_border_col = 4'd14; i_bg_col = 4'd6;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12000; i++) begin
      @(posedge clk);
      #1;
      model_edge();
      check_all();
      i_irq_ack = 1'b0;
      i_ntsc = ((i / 1700) % 2) != 0;
      if ($urandom_range(0, 255) == 0) i_irq_line = 9'($urandom_range(0, 31));
      if ($urandom_range(0, 63) == 0) i_irq_en = 1'($urandom);
      if ($urandom_range(0, 31) == 0) i_irq_ack = 1'b1;
      if ((e % D) == 0 && ((e / D) % cpl(m)) == 0 &&
          (e / (D * cpl(m))) == int'(i_irq_line) && $urandom_range(0, 1) == 1)
        i_irq_ack = 1'b1;
      if ($urandom_range(0, 15) == 0) i_border_col = 4'($urandom);
      if ($urandom_range(0, 15) == 0) i_bg_col = 4'($urandom);
      if (i == 5321) begin
        @(negedge clk);
        #1 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
